// File: rtl/dump_pkg.sv
// Shared types and constants for the buffer dump engine.
// DUMP_CHECKSUM_EN adds a trailing XOR checksum byte to every frame.
package dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    DATA,
    CSUM,
    DONE
  } dump_state_e;

  localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;

  // Total bytes on the wire for a buffer of 2**n entries.
  function automatic int frame_len(input int n);
`ifdef DUMP_CHECKSUM_EN
    return 2 + 4 * (1 << n);
`else
    return 1 + 4 * (1 << n);
`endif
  endfunction

endpackage

// File: rtl/dump_word_ser.sv
// Serialises one 32-bit word as four bytes, MSB first, over a valid/ready handshake.
module dump_word_ser (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        ready_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        last_o
);

  logic [31:0] shift;
  logic [1:0]  byte_cnt;
  logic        active;

  // A load always wins; the word stays put until the sink accepts each byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift    <= '0;
      byte_cnt <= '0;
      active   <= 1'b0;
    end else if (load_i) begin
      shift    <= word_i;
      byte_cnt <= '0;
      active   <= 1'b1;
    end else if (active && ready_i) begin
      shift    <= {shift[23:0], 8'h00};
      byte_cnt <= byte_cnt + 2'd1;
      if (byte_cnt == 2'd3) begin
        active <= 1'b0;
      end
    end
  end

  assign byte_o  = shift[31:24];
  assign valid_o = active;
  assign last_o  = (byte_cnt == 2'd3);

endmodule

// File: rtl/buffer_dump_engine.sv
// Walks every circular-buffer entry and streams it as a framed byte sequence.
// Build with DUMP_CHECKSUM_EN to append an XOR checksum of the data bytes.
module buffer_dump_engine
  import dump_pkg::*;
#(
  parameter int         N        = 6,
  parameter int         IDX_W    = 20,
  parameter logic [7:0] SOF_BYTE = SOF_BYTE_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             freeze_o,
  output logic             done_o,
  output logic [IDX_W-1:0] read_index_o,
  input  logic [31:0]      read_data_i,
  output logic [7:0]       byte_o,
  output logic             byte_valid_o,
  input  logic             byte_ready_i
);

  localparam logic [N-1:0] IDX_LAST = '1;

  dump_state_e state, state_next;
  logic [N-1:0] idx;
  logic         ser_load;
  logic         ser_ready;
  logic         ser_valid;
  logic         ser_last;
  logic [7:0]   ser_byte;
  logic         data_xfer;

  assign ser_ready = (state == DATA) && byte_ready_i;
  assign data_xfer = ser_ready && ser_valid;

  dump_word_ser u_ser (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (ser_load),
    .word_i  (read_data_i),
    .ready_i (ser_ready),
    .byte_o  (ser_byte),
    .valid_o (ser_valid),
    .last_o  (ser_last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The index only moves after the final byte of an entry, so it is stable across LOAD and DATA.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx <= '0;
    end else if (state == IDLE && start_i) begin
      idx <= '0;
    end else if (data_xfer && ser_last && idx != IDX_LAST) begin
      idx <= idx + 1'b1;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csum <= '0;
    end else if (state == IDLE && start_i) begin
      csum <= '0;
    end else if (data_xfer) begin
      csum <= csum ^ ser_byte;
    end
  end
`endif

  // Valid is a function of state alone; ready only steers the next state.
  always_comb begin
    state_next   = state;
    byte_o       = '0;
    byte_valid_o = 1'b0;
    ser_load     = 1'b0;
    done_o       = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_next = HDR;
      end
      HDR: begin
        byte_o       = SOF_BYTE;
        byte_valid_o = 1'b1;
        if (byte_ready_i) state_next = LOAD;
      end
      LOAD: begin
        ser_load   = 1'b1;
        state_next = DATA;
      end
      DATA: begin
        byte_o       = ser_byte;
        byte_valid_o = ser_valid;
        if (data_xfer && ser_last) begin
          if (idx == IDX_LAST) begin
`ifdef DUMP_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end else begin
            state_next = LOAD;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CSUM: begin
        byte_o       = csum;
        byte_valid_o = 1'b1;
        if (byte_ready_i) state_next = DONE;
      end
`endif
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_o       = (state != IDLE);
  assign freeze_o     = busy_o;
  assign read_index_o = IDX_W'(idx);

endmodule

// File: tb/tb_buffer_dump_engine.sv
// Self-checking bench for buffer_dump_engine with a 4-entry buffer model and byte scoreboard.
module tb_buffer_dump_engine;
  import dump_pkg::*;

  localparam int N     = 2;
  localparam int IDX_W = 20;
`ifdef DUMP_CHECKSUM_EN
  localparam int FRAME_CYC = 23;
`else
  localparam int FRAME_CYC = 22;
`endif

  logic             clk;
  logic             rst;
  logic             start_i;
  logic             busy_o;
  logic             freeze_o;
  logic             done_o;
  logic [IDX_W-1:0] read_index_o;
  logic [31:0]      read_data_i;
  logic [7:0]       byte_o;
  logic             byte_valid_o;
  logic             byte_ready_i;

  logic [31:0] mem [4];

  typedef struct {
    logic [7:0] b;
    int         kind;
    int         entry;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0] w0, w1, w2, w3;
    int          rmode;
    int          exp_freeze;
  } vec_t;
  vec_t vecs [4];

  int checks = 0;
  int failures = 0;
  int rx_cnt = 0;
  int ready_mode = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  buffer_dump_engine #(.N(N), .IDX_W(IDX_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .freeze_o     (freeze_o),
    .done_o       (done_o),
    .read_index_o (read_index_o),
    .read_data_i  (read_data_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign read_data_i = (read_index_o < 4) ? mem[read_index_o[1:0]] : 32'hBAD0BAD0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sink: always ready or pseudo-random backpressure.
  initial begin
    byte_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      byte_ready_i = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(byte_valid_o), 32'd1);
        checkOutput("stall_byte", 32'(byte_o), 32'(prev_byte));
      end
      if (byte_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_byte: got %0h expected none", byte_o);
        end else begin
          if (exp_q[0].kind == 1)
            checkOutput("read_index", 32'(read_index_o), 32'(exp_q[0].entry));
          if (byte_ready_i) begin
            checkOutput("stream_byte", 32'(byte_o), 32'(exp_q[0].b));
            void'(exp_q.pop_front());
            rx_cnt++;
          end
        end
      end
      prev_stall = byte_valid_o && !byte_ready_i;
      prev_byte  = byte_o;
    end
  end

  task automatic pushFrame();
    logic [7:0]  cs;
    logic [31:0] w;
    logic [7:0]  b;
    exp_t        e;
    cs = 8'h00;
    e.b = 8'hA5; e.kind = 0; e.entry = 0;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      w = mem[i];
      for (int k = 0; k < 4; k++) begin
        b = w[31 - 8*k -: 8];
        cs = cs ^ b;
        e.b = b; e.kind = 1; e.entry = i;
        exp_q.push_back(e);
      end
    end
`ifdef DUMP_CHECKSUM_EN
    e.b = cs; e.kind = 2; e.entry = 0;
    exp_q.push_back(e);
`endif
  endtask

  task automatic pulseStart();
    @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic applyStimulus(input int rmode, input int exp_freeze);
    int fz, dn;
    bit seen, done_ok;
    fz = 0; dn = 0; seen = 0; done_ok = 0;
    ready_mode = rmode;
    rx_cnt = 0;
    pushFrame();
    pulseStart();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checkOutput("sof_latency_valid", 32'(byte_valid_o), 32'd1);
        checkOutput("busy_after_start", 32'(busy_o), 32'd1);
      end
      if (freeze_o) fz++;
      if (seen && !done_o) begin
        checkOutput("busy_after_done", 32'(busy_o), 32'd0);
        done_ok = 1;
        break;
      end
      if (done_o) begin
        dn++;
        seen = 1;
      end
    end
    checkOutput("frame_completed", 32'(done_ok), 32'd1);
    checkOutput("done_pulses", 32'(dn), 32'd1);
    checkOutput("frame_bytes", 32'(rx_cnt), 32'(frame_len(N)));
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    if (exp_freeze >= 0) checkOutput("freeze_cycles", 32'(fz), 32'(exp_freeze));
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit got;
    vecs[0] = '{32'h80001234, 32'h00000000, 32'hDEADBEEF, 32'h01020304, 0, FRAME_CYC};
    vecs[1] = '{32'h80001234, 32'h00000000, 32'hDEADBEEF, 32'h01020304, 1, -1};
    vecs[2] = '{32'hFFFFFFFF, 32'h7F80C3A5, 32'h5A5A0FF0, 32'hFFFF0001, 1, -1};
    vecs[3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 0, FRAME_CYC};

    rst = 1'b1;
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_freeze", 32'(freeze_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_valid", 32'(byte_valid_o), 32'd0);
    checkOutput("rst_byte", 32'(byte_o), 32'd0);
    checkOutput("rst_index", 32'(read_index_o), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      mem[0] = vecs[v].w0; mem[1] = vecs[v].w1; mem[2] = vecs[v].w2; mem[3] = vecs[v].w3;
      $display("[TB] frame vector %0d", v);
      applyStimulus(vecs[v].rmode, vecs[v].exp_freeze);
    end

    // Start requests during DATA and during DONE must be ignored.
    $display("[TB] start while busy");
    mem[0] = 32'h80001234; mem[1] = 32'h00000000; mem[2] = 32'hDEADBEEF; mem[3] = 32'h01020304;
    ready_mode = 0;
    rx_cnt = 0;
    pushFrame();
    pulseStart();
    repeat (8) @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1;
        break;
      end
    end
    checkOutput("busy_done_seen", 32'(got), 32'd1);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(negedge clk);
    checkOutput("busy_low_after_done", 32'(busy_o), 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("no_second_frame", 32'(busy_o), 32'd0);
    end
    checkOutput("busy_frame_bytes", 32'(rx_cnt), 32'(frame_len(N)));
    exp_q.delete();

    // Reset mid-frame, then a fresh complete frame.
    $display("[TB] reset mid-frame");
    ready_mode = 0;
    rx_cnt = 0;
    pushFrame();
    pulseStart();
    got = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rx_cnt >= 6) begin
        got = 1;
        break;
      end
    end
    checkOutput("six_transfers", 32'(got), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy_o), 32'd0);
    checkOutput("abort_freeze", 32'(freeze_o), 32'd0);
    checkOutput("abort_done", 32'(done_o), 32'd0);
    checkOutput("abort_valid", 32'(byte_valid_o), 32'd0);
    checkOutput("abort_byte", 32'(byte_o), 32'd0);
    checkOutput("abort_index", 32'(read_index_o), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    applyStimulus(0, FRAME_CYC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buffer_dump_engine.md
Name: buffer_dump_engine

Overview:
Downstream consumer of the circular_buffer capture store. On a start pulse it walks every buffer entry via the buffer's combinational read port and serialises the contents as a framed byte stream with a valid/ready handshake, normally feeding the debug UART transmitter. It asserts a freeze flag while dumping so upstream logic can gate buffer writes.

Parameters:
N, 6, log2 of buffer depth; entries dumped = 2**N
IDX_W, 20, width of read_index_o; must match the buffer read port
SOF_BYTE, 8'hA5, frame start-of-frame byte

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  dump request; sampled only in IDLE
busy_o  out  1  high from the cycle after start is accepted until the DONE state exits
freeze_o  out  1  equals busy_o; upstream gates buffer writes with it
done_o  out  1  one-cycle pulse at end of frame
read_index_o  out  IDX_W  entry index to buffer; upper bits above N are zero
read_data_i  in  32  buffer word at read_index_o, combinational, same cycle
byte_o  out  8  stream data
byte_valid_o  out  1  stream valid
byte_ready_i  in  1  stream ready from sink

Behaviour:
- Reset values: busy_o=0, freeze_o=0, done_o=0, byte_valid_o=0, byte_o=0, read_index_o=0. Internal: state=IDLE, checksum=0.
- Reset asserted mid-frame aborts immediately. No trailer is sent. The sink sees byte_valid_o drop.
- Handshake: a transfer occurs on a rising edge with byte_valid_o & byte_ready_i. Once valid is raised, byte_o stays stable and valid stays high until the transfer. Valid never depends combinationally on ready.
- FSM:
  - IDLE: start_i=1 → HDR. Clear index and checksum.
  - HDR: byte_o=SOF_BYTE, valid=1. On transfer → LOAD.
  - LOAD: one cycle, valid=0. Latch read_data_i into a 32-bit shift register. byte_cnt=0 → DATA.
  - DATA: byte_o=shift[31:24], valid=1; bytes go MSB first. On transfer:
    - checksum ^= byte_o; shift left 8; byte_cnt++.
    - After the 4th byte: index == 2**N-1 → CSUM (or DONE when the checksum feature is off). Otherwise index++ → LOAD.
  - CSUM: byte_o=checksum, valid=1. On transfer → DONE.
  - DONE: done_o=1 for exactly one cycle → IDLE. busy_o drops in the following cycle.
- Latency: start accepted in cycle t gives first valid byte (SOF) in cycle t+1, with sink always ready.
- Frame length: 1 + 4·2**N (+1 with checksum) bytes. N=6 gives 257/258 bytes.
- read_index_o is held stable from LOAD through the last DATA byte of that entry.
- start_i while busy is ignored, with no queuing. start_i coincident with the DONE cycle is also ignored.
- Each word is latched atomically in LOAD. Coherence across words is guaranteed only if upstream honours freeze_o.
- byte_ready_i held low indefinitely stalls the FSM with no timeout.
- Index arithmetic is N bits wide, zero-extended to IDX_W.

Optional Feature:
DUMP_CHECKSUM_EN
- Defined: the CSUM state exists. A trailing byte is sent, equal to the XOR of all 4·2**N data bytes; the SOF byte is excluded.
- Undefined: no CSUM state and no checksum register. DATA goes straight to DONE after the last byte, and the frame is 1 + 4·2**N bytes.

Decomposition:
- Package dump_pkg contains:
  - state enum dump_state_e (IDLE, HDR, LOAD, DATA, CSUM, DONE);
  - SOF_BYTE default constant;
  - helper function frame_len(N).
- One sub-module, dump_word_ser: 32-bit load, 4-byte MSB-first shift with valid/ready, and a last-byte flag. The top FSM handles framing, indexing and the checksum.

Test Plan:
- Basic frame, N=2, DUMP_CHECKSUM_EN defined:
  - Stimulus: entries {0x80001234, 0x00000000, 0xDEADBEEF, 0x01020304}; sink always ready; start pulse.
  - Required: bytes A5 80 00 12 34 00 00 00 00 DE AD BE EF 01 02 03 04 80, then one done_o pulse.
- Backpressure: same setup, byte_ready_i toggled pseudo-randomly.
  - Required: identical byte sequence; byte_o/byte_valid_o stable while stalled; read_index_o stable within each entry.
- Start while busy: second start_i during DATA and during DONE.
  - Required: ignored; exactly one frame; busy_o low one cycle after done_o.
- Reset mid-frame: rst_i asserted after the 6th transfer.
  - Required: all outputs return to reset values immediately.
  - A new start then yields a complete frame beginning with A5.
- Feature off, N=2, same data.
  - Required: 17 bytes ending ...03 04, then done_o; no checksum byte.
- Freeze timing: with the sink always ready, freeze_o is high from cycle t+1 to the cycle after done_o.
  - Required duration: 1+16+1+4 (LOAD) + 1 (DONE) = 23 cycles with the checksum, for N=2.
